matrix_multiply_seq: RTL and testbench

MATRIX_MULTIPLY_SEQ -- requirements
Module: matrix_multiply_seq

---
 rtl/matrix_multiply_seq.sv | 140 ++++++++++++++
 tb/tb_matrix_multiply_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/matrix_multiply_seq.sv
// rtl/matrix_multiply_seq.sv - sequential NxN unsigned matrix multiply-accumulate, one MAC per cycle
//
// Purpose: captures A and B on an accept handshake, then computes C = A*B (or C += A*B
// when in_acc=1) over N^3 cycles and holds C until the consumer takes it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (A, B, in_acc qualified by in_valid)
//   A, B                NxN operands, row-major, element (0,0) in the MSBs
//   in_acc              1 = accumulate onto the held C, 0 = overwrite C
//   out_valid/out_ready result handshake
//   C                   NxN result, CW bits per element, same packing as A
//   busy                high while computing
module matrix_multiply_seq #(
    parameter int  N  = 2,
    parameter int  W  = 2,
    localparam int CW = 2 * W + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*W-1:0]  A,
    input  logic [N*N*W-1:0]  B,
    input  logic              in_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*CW-1:0] C,
    output logic              busy
);

    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [N*N*W-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    c_q [N*N];
    logic [CW-1:0]    c_d [N*N];
    logic             in_ready_q, out_valid_q, busy_q;

    int               a_idx, b_idx, c_idx;
    logic [CW-1:0]    a_el, b_el;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;

        a_idx = int'(i_q) * N + int'(k_q);
        b_idx = int'(k_q) * N + int'(j_q);
        c_idx = int'(i_q) * N + int'(j_q);
        // Element e sits (N*N-1-e) elements above the LSB; zero-extend to CW so the
        // product and the sum are both formed at full result width.
        a_el = CW'(W'(a_q >> ((N * N - 1 - a_idx) * W)));
        b_el = CW'(W'(b_q >> ((N * N - 1 - b_idx) * W)));

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = A;
                    b_d = B;
                    i_d = '0;
                    j_d = '0;
                    k_d = '0;
                    if (!in_acc) begin
                        for (int e = 0; e < N * N; e++) c_d[e] = '0;
                    end
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                for (int e = 0; e < N * N; e++) begin
                    if (e == c_idx) c_d[e] = c_q[e] + a_el * b_el;
                end
                // k fastest, then j, then i; the final MAC retires to DONE.
                if (k_q == LAST) begin
                    k_d = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            for (int e = 0; e < N * N; e++) c_q[e] <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == COMPUTE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    for (genvar g = 0; g < N * N; g++) begin : g_pack
        assign C[(N*N-1-g)*CW +: CW] = c_q[g];
    end

endmodule

// File: tb/tb_matrix_multiply_seq.sv
// tb/tb_matrix_multiply_seq.sv - directed self-checking bench for matrix_multiply_seq
module tb_matrix_multiply_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Small instance: N=2, W=2, CW=5
    logic        in_valid = 1'b0, in_acc = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [7:0]  a_s = '0, b_s = '0;
    logic [19:0] c_s;

    // Large instance: N=4, W=8, CW=18
    logic         in_valid4 = 1'b0, in_acc4 = 1'b0, out_ready4 = 1'b0;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] a4 = '0, b4 = '0;
    logic [287:0] c4;

    int total = 0;
    int bad   = 0;

    matrix_multiply_seq #(.N(2), .W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_s), .B(b_s), .in_acc(in_acc), .out_valid(out_valid),
        .out_ready(out_ready), .C(c_s), .busy(busy)
    );

    matrix_multiply_seq #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(a4), .B(b4), .in_acc(in_acc4), .out_valid(out_valid4),
        .out_ready(out_ready4), .C(c4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic acc);
        a_s = a; b_s = b; in_acc = acc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until out_valid; optionally scrambles inputs.
    task automatic wait_done(input bit scramble, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            if (scramble) begin
                a_s = 8'($urandom); b_s = 8'($urandom);
                in_acc = 1'($urandom); in_valid = 1'($urandom);
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    localparam logic [7:0]  A1 = {2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic [7:0]  B1 = {2'd2, 2'd1, 2'd0, 2'd3};
    localparam logic [19:0] C1 = {5'd2, 5'd7, 5'd6, 5'd3};
    localparam logic [7:0]  ALL3 = 8'hFF;

    initial begin
        int cyc;
        bit stable;
        logic [287:0] exp4;

        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_c", 512'(c_s), 512'(0));

        // Basic product and latency
        start(A1, B1, 1'b0);
        chk("acc_busy", 512'(busy), 512'(1));
        chk("acc_in_ready", 512'(in_ready), 512'(0));
        wait_done(1'b0, cyc);
        chk("lat_n2", 512'(cyc), 512'(8));
        chk("c_basic", 512'(c_s), 512'(C1));
        chk("done_busy", 512'(busy), 512'(0));

        // Backpressure: hold 20 cycles in DONE
        stable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (c_s !== C1 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", 512'(stable), 512'(1));
        // Release with in_valid already high: must not accept on the release edge
        a_s = ALL3; b_s = ALL3; in_acc = 1'b0; in_valid = 1'b1;
        release_out();
        chk("rel_in_ready", 512'(in_ready), 512'(1));
        chk("rel_out_valid", 512'(out_valid), 512'(0));
        chk("rel_no_accept", 512'(busy), 512'(0));
        chk("rel_c_kept", 512'(c_s), 512'(C1));

        // All-3 overwrite, then accumulate with wrap (36 mod 32)
        start(ALL3, ALL3, 1'b0);
        wait_done(1'b0, cyc);
        chk("c_all3", 512'(c_s), 512'({4{5'd18}}));
        release_out();
        start(ALL3, ALL3, 1'b1);
        wait_done(1'b0, cyc);
        chk("c_acc_wrap", 512'(c_s), 512'({4{5'd4}}));
        release_out();

        // Reset three cycles into COMPUTE
        start(ALL3, ALL3, 1'b1);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_c", 512'(c_s), 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_in_ready", 512'(in_ready), 512'(1));
        stable = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            if (out_valid !== 1'b0) stable = 1'b0;
        end
        chk("mid_rst_no_out", 512'(stable), 512'(1));
        // Accumulate onto the cleared C gives the plain product
        start(A1, B1, 1'b1);
        wait_done(1'b0, cyc);
        chk("post_rst_c", 512'(c_s), 512'(C1));
        release_out();

        // Input isolation during COMPUTE
        start(A1, B1, 1'b0);
        wait_done(1'b1, cyc);
        chk("iso_lat", 512'(cyc), 512'(8));
        chk("iso_c", 512'(c_s), 512'(C1));
        release_out();

        // N=4, W=8, all 255
        a4 = '1; b4 = '1; in_acc4 = 1'b0; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 500) begin
            step();
            cyc++;
        end
        chk("lat_n4", 512'(cyc), 512'(64));
        for (int e = 0; e < 16; e++) exp4[e*18 +: 18] = 18'd260100;
        chk("c_n4", 512'(c4), 512'(exp4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
